// File: rtl/uart_rx_frame_check.sv
// UART receive framer: start detect, 3-sample majority data recovery,
// parity and stop checking with one-cycle result pulses.
module uart_rx_frame_check #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESC_W    = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [PRESC_W-1:0]    Prescale,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  Data_Valid,
  output logic                  Par_err,
  output logic                  Stp_err
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [PRESC_W-1:0]    r_presc;
  logic [PRESC_W-1:0]    r_edge_cnt;
  logic [BW-1:0]         r_bit_cnt;
  logic [2:0]            r_samp;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_par_en;
  logic                  r_par_typ;
  logic                  r_par_fail;

  logic [PRESC_W-1:0]    w_norm_p;
  logic [PRESC_W-1:0]    w_half;
  logic                  w_last;
  logic                  w_s0;
  logic                  w_s1;
  logic                  w_s2;
  logic                  w_maj;
  logic                  w_last_bit;
  logic                  w_exp_par;

  // Anything but 8/16/32 falls back to 16x oversampling
  assign w_norm_p =
    (Prescale == PRESC_W'(8) ||
     Prescale == PRESC_W'(16) ||
     Prescale == PRESC_W'(32)) ?
    Prescale : PRESC_W'(16);

  assign w_half = {1'b0, r_presc[PRESC_W-1:1]};
  assign w_last = (r_edge_cnt == r_presc - PRESC_W'(1));
  assign w_s0   = (r_edge_cnt == w_half - PRESC_W'(1));
  assign w_s1   = (r_edge_cnt == w_half);
  assign w_s2   = (r_edge_cnt == w_half + PRESC_W'(1));

  assign w_maj = (r_samp[0] & r_samp[1]) |
                 (r_samp[0] & r_samp[2]) |
                 (r_samp[1] & r_samp[2]);

  assign w_last_bit = (r_bit_cnt == BW'(DATA_WIDTH - 1));
  assign w_exp_par  = r_par_typ ? ~^r_shift : ^r_shift;

  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (!RX_IN) w_next = S_START;
      S_START:  if (w_last) w_next = w_maj ? S_IDLE : S_DATA;
      S_DATA:
        if (w_last && w_last_bit)
          w_next = r_par_en ? S_PARITY : S_STOP;
      S_PARITY: if (w_last) w_next = S_STOP;
      S_STOP:   if (w_last) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_presc    <= PRESC_W'(16);
      r_edge_cnt <= '0;
      r_bit_cnt  <= '0;
      r_samp     <= '0;
      r_shift    <= '0;
      r_par_en   <= 1'b0;
      r_par_typ  <= 1'b0;
      r_par_fail <= 1'b0;
      P_DATA     <= '0;
      Data_Valid <= 1'b0;
      Par_err    <= 1'b0;
      Stp_err    <= 1'b0;
    end else begin
      Data_Valid <= 1'b0;
      Par_err    <= 1'b0;
      Stp_err    <= 1'b0;

      // Detect cycle is edge 0 of the start bit
      if (r_state == S_IDLE) begin
        r_edge_cnt <= RX_IN ? '0 : PRESC_W'(1);
        if (!RX_IN) begin
          r_presc    <= w_norm_p;
          r_par_en   <= PAR_EN;
          r_par_typ  <= PAR_TYP;
          r_par_fail <= 1'b0;
          r_bit_cnt  <= '0;
        end
      end else begin
        r_edge_cnt <= w_last ? '0 :
                      r_edge_cnt + PRESC_W'(1);
        if (w_s0) r_samp[0] <= RX_IN;
        if (w_s1) r_samp[1] <= RX_IN;
        if (w_s2) r_samp[2] <= RX_IN;
      end

      if (r_state == S_DATA && w_last) begin
        r_shift   <= {w_maj, r_shift[DATA_WIDTH-1:1]};
        r_bit_cnt <= w_last_bit ? '0 :
                     r_bit_cnt + BW'(1);
      end

      if (r_state == S_PARITY && w_last)
        r_par_fail <= (w_maj != w_exp_par);

      if (r_state == S_STOP && w_last) begin
        Data_Valid <= w_maj & ~r_par_fail;
        Par_err    <= r_par_fail;
        Stp_err    <= ~w_maj;
        if (w_maj && !r_par_fail)
          P_DATA <= r_shift;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_check.sv
// Scoreboard bench for uart_rx_frame_check: frames are driven bit by bit,
// expected results come from frame-level rules and are checked on pulses.
module tb_uart_rx_frame_check;

  logic       CLK = 1'b0;
  logic       RST;
  logic       RX_IN;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [5:0] Prescale;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       Par_err;
  logic       Stp_err;

  uart_rx_frame_check #(
    .DATA_WIDTH(8),
    .PRESC_W(6)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .RX_IN(RX_IN),
    .PAR_EN(PAR_EN),
    .PAR_TYP(PAR_TYP),
    .Prescale(Prescale),
    .P_DATA(P_DATA),
    .Data_Valid(Data_Valid),
    .Par_err(Par_err),
    .Stp_err(Stp_err)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic       dv;
    logic       pe;
    logic       se;
    logic [7:0] data;
    int         at;
  } exp_t;

  exp_t       q[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] last_good = 8'h00;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h, want %h", nm, act, want);
    end
  endtask

  // Expected result of one complete frame, from the line-level rules
  task automatic push_exp(input logic [7:0] d, input logic pen,
                          input logic ptyp, input logic pbit,
                          input logic stop, input int start,
                          input int p);
    exp_t e;
    logic want_par;
    want_par = ptyp ? ~^d : ^d;
    e.pe = pen && (pbit != want_par);
    e.se = !stop;
    e.dv = !e.pe && !e.se;
    if (e.dv) last_good = d;
    e.data = last_good;
    e.at = start + (10 + int'(pen)) * p - 1;
    q.push_back(e);
  endtask

  always @(negedge CLK) begin
    if (Data_Valid === 1'b1 || Par_err === 1'b1 ||
        Stp_err === 1'b1) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: dv=%0b pe=%0b se=%0b cyc=%0d",
                 Data_Valid, Par_err, Stp_err, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (Data_Valid !== e.dv || Par_err !== e.pe ||
            Stp_err !== e.se || P_DATA !== e.data ||
            cyc != e.at) begin
          errors++;
          $display({"FAIL frame: got dv=%0b pe=%0b se=%0b data=%h ",
                    "cyc=%0d, want dv=%0b pe=%0b se=%0b data=%h cyc=%0d"},
                   Data_Valid, Par_err, Stp_err, P_DATA, cyc,
                   e.dv, e.pe, e.se, e.data, e.at);
        end
      end
    end
  end

  task automatic idle(input int n);
    RX_IN = 1'b1;
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Drive one whole frame; nb/noff place a single flipped cycle
  task automatic send(input logic [7:0] d, input int pv,
                      input logic pen, input logic ptyp,
                      input logic pbit, input logic stop,
                      input int nb, input int noff,
                      input bit scr);
    int p;
    int nbits;
    int start;
    logic [10:0] fr;
    logic v;
    p = (pv == 8 || pv == 16 || pv == 32) ? pv : 16;
    Prescale = 6'(pv);
    PAR_EN = pen;
    PAR_TYP = ptyp;
    nbits = pen ? 11 : 10;
    fr = pen ? {stop, pbit, d, 1'b0} : {1'b0, stop, d, 1'b0};
    start = 0;
    for (int b = 0; b < nbits; b++) begin
      for (int k = 0; k < p; k++) begin
        v = fr[b];
        if (b == nb && k == noff) v = ~v;
        RX_IN = v;
        @(posedge CLK);
        #1;
        if (b == 0 && k == 0) begin
          start = cyc;
          if (scr) begin
            Prescale = 6'($urandom);
            PAR_EN = 1'($urandom);
            PAR_TYP = 1'($urandom);
          end
        end
      end
    end
    push_exp(d, pen, ptyp, pbit, stop, start, p);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_pdata"}, 32'(P_DATA), 32'h0);
    chk({nm, "_flags"},
        {29'd0, Data_Valid, Par_err, Stp_err}, 32'h0);
  endtask

  initial begin
    RST = 1'b1;
    RX_IN = 1'b1;
    PAR_EN = 1'b0;
    PAR_TYP = 1'b0;
    Prescale = 6'd16;
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
    chk_zero("reset");
    idle(4);

    send(8'hA5, 8, 1, 0, 1'b0, 1, -1, 0, 0);
    idle(3);
    send(8'h3C, 16, 1, 1, 1'b0, 1, -1, 0, 0);
    idle(2);
    send(8'h81, 16, 0, 0, 1'b0, 0, -1, 0, 0);
    send(8'h7E, 16, 0, 0, 1'b0, 1, -1, 0, 0);
    idle(2);

    // start-bit glitch at 32x
    Prescale = 6'd32;
    PAR_EN = 1'b0;
    RX_IN = 1'b0;
    repeat (10) begin
      @(posedge CLK);
      #1;
    end
    idle(40);
    send(8'h55, 32, 0, 0, 1'b0, 1, -1, 0, 0);

    send(8'h00, 8, 1, 0, 1'b0, 1, -1, 0, 0);
    send(8'hFF, 8, 1, 0, 1'b0, 1, -1, 0, 0);
    send(8'h69, 8, 1, 0, 1'b0, 1, 3, 4, 0);
    idle(2);

    // reset in the middle of the data bits of 0x12
    Prescale = 6'd8;
    PAR_EN = 1'b1;
    PAR_TYP = 1'b0;
    for (int i = 0; i < 40; i++) begin
      logic [8:0] f;
      f = {8'h12, 1'b0};
      RX_IN = f[i / 8];
      @(posedge CLK);
      #1;
    end
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    last_good = 8'h00;
    chk_zero("midreset");
    idle(20);
    send(8'h34, 8, 1, 0, 1'b1, 1, -1, 0, 0);
    idle(1);

    send(8'hC3, 20, 1, 1, 1'b1, 1, -1, 0, 0);
    idle(1);

    // line stuck low: all-zero frames with a zero stop bit
    for (int i = 0; i < 3; i++)
      send(8'h00, 8, 1, 0, 1'b0, 0, -1, 0, 0);
    idle(2);

    for (int n = 0; n < 40; n++) begin
      logic [7:0] d;
      int pv;
      logic pen, ptyp, pbit, stop;
      int nb, noff;
      d = 8'($urandom);
      case ($urandom_range(0, 3))
        0: pv = 8;
        1: pv = 16;
        2: pv = 32;
        default: pv = int'($urandom_range(0, 63));
      endcase
      pen = 1'($urandom);
      ptyp = 1'($urandom);
      pbit = ptyp ? ~^d : ^d;
      if ($urandom_range(0, 3) == 0) pbit = ~pbit;
      stop = ($urandom_range(0, 4) != 0);
      nb = ($urandom_range(0, 1) == 1) ?
           int'($urandom_range(1, 8)) : -1;
      noff = int'($urandom_range(0, 7));
      send(d, pv, pen, ptyp, pbit, stop, nb, noff, 1);
      idle(int'($urandom_range(0, 3)));
    end

    idle(20);
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
